multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle successor to the single-cycle control decoder: a Moore finite state machine (FSM) that sequences each MIPS instruction through fetch, decode, execute, memory and writeback states. It generates per-state datapath controls for the shared-ALU multicycle datapath. It adds a memory ready handshake and a parametrised wait state for the multi-cycle `mul` accelerator. The ReLU write path (`RegWrite2`) is retained behind a parameter.

## Interface
- `MUL_LAT`, 4, cycles the mul unit needs after `mul_start`; legal range 1..2^CNT_W-1
- `CNT_W`, 4, width of the mul wait counter
- `ENABLE_RELU`, 1, 1 = R-type funct 0x2e decoded as relu; 0 = illegal
- `clk` in 1: single clock; all state changes on the rising edge
- `reset` in 1: asynchronous, active-low
- `OpCode` in 6: instruction register [31:26]; valid from ID onward
- `Funct` in 6: instruction register [5:0]
- `Zero` in 1: ALU zero flag; used in EX for beq
- `mem_ready` in 1: memory completes the current access this cycle
- `PCWrite` out 1: unconditional PC load
- `IorD` out 1: memory address select; 0 = PC, 1 = ALUOut
- `MemRead` out 1: memory read strobe
- `MemWrite` out 1: memory write strobe
- `IRWrite` out 1: instruction register load
- `RegWrite` out 1: register file write
- `RegWrite2` out 1: relu write strobe
- `RegDst` out 2: 0 = rt, 1 = rd, 2 = $ra
- `MemtoReg` out 2: 0 = ALUOut, 1 = MDR, 2 = PC
- `ALUSrcA` out 2: 0 = PC, 1 = rs, 2 = shamt
- `ALUSrcB` out 2: 0 = rt, 1 = const 4, 2 = ext imm, 3 = ext imm<<2
- `ALUOp` out 4: ALU control code
- `PCSrc` out 2: 0 = ALU result, 1 = jump target, 2 = rs, 3 = ALUOut
- `ExtOp` out 1: immediate extension; 1 = sign-extend, 0 = zero-extend (andi only)
- `LuOp` out 1: lui immediate select
- `mul_start` out 1: one-cycle start pulse to the mul unit
- `illegal` out 1: one-cycle pulse flagging an undecoded instruction
- `state` out 3: current state, for debug

## Operation
- State encoding: IF = 0, ID = 1, EX = 2, MEM = 3, WB = 4, MULW = 5.
- Outputs are a Moore function of `state` plus latched `op_q`/`funct_q`. Any output not named for a state is 0.
- `op_q`/`funct_q` are loaded from `OpCode`/`Funct` on the clock edge leaving ID.
- **IF**
  - Drive `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=1, `ALUOp`=0.
  - `IRWrite`=`PCWrite`=`mem_ready`, `PCSrc`=0.
  - Go to ID when `mem_ready`; otherwise stay in IF.
- **ID**
  - Drive `ALUSrcA`=0, `ALUSrcB`=3, `ALUOp`=0; ALUOut captures the branch target.
  - Decode is taken from live `OpCode`/`Funct`.
  - j (0x02): `PCWrite`, `PCSrc`=1; go to IF.
  - jal (0x03): `PCWrite`, `PCSrc`=1, `RegWrite`, `RegDst`=2, `MemtoReg`=2; go to IF.
  - jr (0x00/0x08): `PCWrite`, `PCSrc`=2; go to IF.
  - jalr (0x00/0x09): `PCWrite`, `PCSrc`=2, `RegWrite`, `RegDst`=1, `MemtoReg`=2; go to IF.
  - Undecoded instruction: pulse `illegal`; go to IF with no writes.
  - All other instructions: go to EX.
- **EX**
  - `ALUSrcA` = 2 for sll/srl/sra (funct 0x00/0x02/0x03); otherwise 1.
  - `ALUSrcB` = 2 for lw, sw, lui, addi, addiu, andi, slti, sltiu; otherwise 0.
  - `ExtOp` = 0 only for andi (0x0c); `LuOp` = 1 only for lui (0x0f).
  - `ALUOp[2:0]`: R-type → 010; beq → 001; andi → 100; slti/sltiu → 101; mul (0x1c/0x02) → 110; otherwise 000.
  - `ALUOp[3]` = `op_q[0]`.
  - beq: `PCWrite` = `Zero`, `PCSrc`=3; go to IF.
  - lw/sw: go to MEM.
  - mul: pulse `mul_start`, load counter with `MUL_LAT`-1; go to MULW.
  - All others: go to WB.
- **MULW**
  - Hold the EX `ALUOp`.
  - When the counter is 0, go to WB; otherwise decrement the counter.
  - Total MULW cycles = `MUL_LAT`.
- **MEM**
  - `IorD`=1; `MemRead` = lw, `MemWrite` = sw; both held until `mem_ready`.
  - On `mem_ready`: lw goes to WB, sw goes to IF.
- **WB**
  - `RegWrite`=1.
  - `RegDst`: 0 for lw and I-type ALU ops, 1 for R-type and mul.
  - `MemtoReg`: 1 for lw, otherwise 0.
  - relu (when `ENABLE_RELU`): `RegWrite2`=1 as well.
  - Go to IF.

## Timing
- Reset asserted (`reset`=0):
  - State → IF; counter, `op_q` and `funct_q` → 0.
  - All outputs forced to 0 combinationally, including `MemRead`; `state` reads 0.
- After reset release, the first IF outputs appear in the same cycle.
- Reset mid-instruction aborts the instruction; no partial write completes after reset asserts.
- Cycle counts with `mem_ready` tied high:
  - j/jal/jr/jalr: 2 cycles.
  - beq: 3 cycles.
  - R-type and I-type ALU ops: 4 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.
  - mul: 4 + `MUL_LAT` cycles.
- Each low cycle of `mem_ready` in IF or MEM adds exactly one cycle. Strobes stay asserted and stable for the whole wait.
- `mul_start` is high exactly one cycle per mul instruction.
- `illegal` is high exactly one cycle (ID) per undecoded instruction.
- `OpCode`/`Funct` changes after ID have no effect.

## Test plan
- Reset held low 3 cycles, then released; `mem_ready`=1:
  - During reset: all outputs 0, `state`=0.
  - Cycle after release: `MemRead`=1, `IRWrite`=1, `PCWrite`=1.
- addi (0x08), `mem_ready`=1:
  - States IF, ID, EX, WB.
  - EX: `ALUSrcB`=2, `ALUOp`=0000.
  - WB: `RegWrite`=1, `RegDst`=0.
- lw with `mem_ready` low 2 cycles in MEM:
  - 7 cycles total.
  - `MemRead`/`IorD` high across all 3 MEM cycles.
  - WB: `MemtoReg`=1.
- mul (0x1c/0x02) with `MUL_LAT`=4:
  - `mul_start` high for one cycle in EX.
  - 4 MULW cycles, then WB with `RegDst`=1; 8 cycles total.
- beq:
  - `Zero`=1: `PCWrite`=1, `PCSrc`=3.
  - `Zero`=0: `PCWrite`=0.
  - Both cases return to IF after 3 cycles.
- relu (0x00/0x2e):
  - `ENABLE_RELU`=1: WB has `RegWrite`=1, `RegWrite2`=1.
  - `ENABLE_RELU`=0: `illegal` pulses in ID, no writes, IF next.
- Reset asserted in MULW: state is 0 asynchronously and no WB occurs.

Source files
------------

// File: rtl/multicycle_control.sv
// Moore control FSM for the shared-ALU multicycle MIPS datapath: sequences
// IF/ID/EX/MEM/WB with a memory ready handshake and a counted mul wait state.
module multicycle_control #(
   parameter int MUL_LAT     = 4,
   parameter int CNT_W       = 4,
   parameter bit ENABLE_RELU = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] OpCode,
   input  logic [5:0] Funct,
   input  logic       Zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       RegWrite2,
   output logic [1:0] RegDst,
   output logic [1:0] MemtoReg,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [3:0] ALUOp,
   output logic [1:0] PCSrc,
   output logic       ExtOp,
   output logic       LuOp,
   output logic       mul_start,
   output logic       illegal,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      StIf   = 3'd0,
      StId   = 3'd1,
      StEx   = 3'd2,
      StMem  = 3'd3,
      StWb   = 3'd4,
      StMulw = 3'd5
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03,
                          OP_BEQ   = 6'h04, OP_ADDI = 6'h08, OP_ADDIU = 6'h09,
                          OP_SLTI  = 6'h0a, OP_SLTIU = 6'h0b, OP_ANDI = 6'h0c,
                          OP_LUI   = 6'h0f, OP_MUL  = 6'h1c, OP_LW    = 6'h23,
                          OP_SW    = 6'h2b;
   localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03,
                          FN_JR  = 6'h08, FN_JALR = 6'h09, FN_RELU = 6'h2e,
                          FN_MUL = 6'h02;

   function automatic logic isLegal(input logic [5:0] op, input logic [5:0] fn);
      logic ok;
      ok = 1'b0;
      case (op)
         OP_RTYPE: begin
            case (fn)
               6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h20, 6'h21, 6'h22, 6'h23,
               6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b: ok = 1'b1;
               FN_RELU: ok = ENABLE_RELU;
               default: ok = 1'b0;
            endcase
         end
         OP_J, OP_JAL, OP_BEQ, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI,
         OP_LUI, OP_LW, OP_SW: ok = 1'b1;
         OP_MUL:  ok = (fn == FN_MUL);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   state_t           st;
   logic [CNT_W-1:0] cnt;
   logic [5:0]       opQ, functQ;

   // ID decodes the live instruction register; later states use the latched copy
   logic idJr, idJalr, idJump, idLegal;
   assign idJr    = (OpCode == OP_RTYPE) && (Funct == FN_JR);
   assign idJalr  = (OpCode == OP_RTYPE) && (Funct == FN_JALR);
   assign idJump  = (OpCode == OP_J) || (OpCode == OP_JAL) || idJr || idJalr;
   assign idLegal = isLegal(OpCode, Funct);

   logic rType, isMul, isLw, isSw, isBeq, isShift, immB;
   logic [2:0] aluLo;
   logic [3:0] exAluOp;
   assign rType   = (opQ == OP_RTYPE);
   assign isMul   = (opQ == OP_MUL) && (functQ == FN_MUL);
   assign isLw    = (opQ == OP_LW);
   assign isSw    = (opQ == OP_SW);
   assign isBeq   = (opQ == OP_BEQ);
   assign isShift = rType && ((functQ == FN_SLL) || (functQ == FN_SRL) || (functQ == FN_SRA));
   assign immB    = isLw || isSw || (opQ == OP_LUI) || (opQ == OP_ADDI) || (opQ == OP_ADDIU)
                 || (opQ == OP_ANDI) || (opQ == OP_SLTI) || (opQ == OP_SLTIU);
   assign aluLo   = rType                                  ? 3'b010 :
                    isBeq                                  ? 3'b001 :
                    (opQ == OP_ANDI)                       ? 3'b100 :
                    ((opQ == OP_SLTI) || (opQ == OP_SLTIU)) ? 3'b101 :
                    isMul                                  ? 3'b110 : 3'b000;
   assign exAluOp = {opQ[0], aluLo};

   // NOTE: state is updated with non-blocking assignments under an asynchronous
   // reset so every flop samples pre-edge values and clears the instant reset falls.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st     <= StIf;
         cnt    <= '0;
         opQ    <= '0;
         functQ <= '0;
      end else begin
         case (st)
            StIf: if (mem_ready) st <= StId;
            StId: begin
               opQ    <= OpCode;
               functQ <= Funct;
               st     <= (!idLegal || idJump) ? StIf : StEx;
            end
            StEx: begin
               if (isBeq) st <= StIf;
               else if (isLw || isSw) st <= StMem;
               else if (isMul) begin
                  cnt <= CNT_W'(MUL_LAT - 1);
                  st  <= StMulw;
               end else st <= StWb;
            end
            StMulw: begin
               if (cnt == '0) st <= StWb;
               else cnt <= cnt - 1'b1;
            end
            StMem: if (mem_ready) st <= isLw ? StWb : StIf;
            StWb:    st <= StIf;
            default: st <= StIf;
         endcase
      end
   end

   // NOTE: every output gets a default before the case so no path infers a latch.
   always_comb begin
      PCWrite   = 1'b0;
      IorD      = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      RegWrite2 = 1'b0;
      RegDst    = 2'd0;
      MemtoReg  = 2'd0;
      ALUSrcA   = 2'd0;
      ALUSrcB   = 2'd0;
      ALUOp     = 4'd0;
      PCSrc     = 2'd0;
      ExtOp     = 1'b0;
      LuOp      = 1'b0;
      mul_start = 1'b0;
      illegal   = 1'b0;
      if (reset) begin
         case (st)
            StIf: begin
               MemRead = 1'b1;
               ALUSrcB = 2'd1;
               IRWrite = mem_ready;
               PCWrite = mem_ready;
            end
            StId: begin
               ALUSrcB = 2'd3;
               if (!idLegal) illegal = 1'b1;
               else if (idJump) begin
                  PCWrite = 1'b1;
                  PCSrc   = (idJr || idJalr) ? 2'd2 : 2'd1;
                  if (OpCode == OP_JAL || idJalr) begin
                     RegWrite = 1'b1;
                     RegDst   = idJalr ? 2'd1 : 2'd2;
                     MemtoReg = 2'd2;
                  end
               end
            end
            StEx: begin
               ALUSrcA = isShift ? 2'd2 : 2'd1;
               ALUSrcB = immB ? 2'd2 : 2'd0;
               ExtOp   = (opQ != OP_ANDI);
               LuOp    = (opQ == OP_LUI);
               ALUOp   = exAluOp;
               if (isBeq) begin
                  PCWrite = Zero;
                  PCSrc   = 2'd3;
               end
               mul_start = isMul;
            end
            StMulw: ALUOp = exAluOp;
            StMem: begin
               IorD     = 1'b1;
               MemRead  = isLw;
               MemWrite = isSw;
            end
            StWb: begin
               RegWrite  = 1'b1;
               RegDst    = (rType || isMul) ? 2'd1 : 2'd0;
               MemtoReg  = isLw ? 2'd1 : 2'd0;
               RegWrite2 = ENABLE_RELU && rType && (functQ == FN_RELU);
            end
            default: ;
         endcase
      end
   end

   assign state = st;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: two instances (relu on, MUL_LAT=4;
// relu off, MUL_LAT=2) compared cycle by cycle with an instruction-level model.
module tb_multicycle_control;

   localparam int LAT_A = 4;
   localparam int LAT_B = 2;

   typedef struct packed {
      logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegWrite2;
      logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB;
      logic [3:0] ALUOp;
      logic [1:0] PCSrc;
      logic       ExtOp, LuOp, mulStart, illegal;
      logic [2:0] state;
   } ctrl_t;

   logic       clk = 1'b0;
   logic [1:0] rstN;
   logic [5:0] OpCode, Funct;
   logic       Zero, mem_ready;

   logic       oPCWrite [2], oIorD [2], oMemRead [2], oMemWrite [2], oIRWrite [2];
   logic       oRegWrite [2], oRegWrite2 [2], oExtOp [2], oLuOp [2], oMulStart [2], oIllegal [2];
   logic [1:0] oRegDst [2], oMemtoReg [2], oALUSrcA [2], oALUSrcB [2], oPCSrc [2];
   logic [3:0] oALUOp [2];
   logic [2:0] oState [2];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : gDut
      multicycle_control #(
         .MUL_LAT    ((g == 0) ? LAT_A : LAT_B),
         .CNT_W      (4),
         .ENABLE_RELU(g == 0)
      ) dut (
         .clk(clk), .reset(rstN[g]), .OpCode(OpCode), .Funct(Funct), .Zero(Zero),
         .mem_ready(mem_ready), .PCWrite(oPCWrite[g]), .IorD(oIorD[g]),
         .MemRead(oMemRead[g]), .MemWrite(oMemWrite[g]), .IRWrite(oIRWrite[g]),
         .RegWrite(oRegWrite[g]), .RegWrite2(oRegWrite2[g]), .RegDst(oRegDst[g]),
         .MemtoReg(oMemtoReg[g]), .ALUSrcA(oALUSrcA[g]), .ALUSrcB(oALUSrcB[g]),
         .ALUOp(oALUOp[g]), .PCSrc(oPCSrc[g]), .ExtOp(oExtOp[g]), .LuOp(oLuOp[g]),
         .mul_start(oMulStart[g]), .illegal(oIllegal[g]), .state(oState[g])
      );
   end

   int         errors = 0;
   int         checks = 0;
   int         curDut = 0;
   int         lat = LAT_A;
   bit         en = 1'b1;
   logic [5:0] curOp, curFn;
   logic [11:0] pool [20];

   function automatic ctrl_t obsOf(input int g);
      ctrl_t o;
      o.PCWrite = oPCWrite[g];   o.IorD = oIorD[g];         o.MemRead = oMemRead[g];
      o.MemWrite = oMemWrite[g]; o.IRWrite = oIRWrite[g];   o.RegWrite = oRegWrite[g];
      o.RegWrite2 = oRegWrite2[g]; o.RegDst = oRegDst[g];   o.MemtoReg = oMemtoReg[g];
      o.ALUSrcA = oALUSrcA[g];   o.ALUSrcB = oALUSrcB[g];   o.ALUOp = oALUOp[g];
      o.PCSrc = oPCSrc[g];       o.ExtOp = oExtOp[g];       o.LuOp = oLuOp[g];
      o.mulStart = oMulStart[g]; o.illegal = oIllegal[g];   o.state = oState[g];
      return o;
   endfunction

   task automatic checkNow(input int g, input ctrl_t exp, input string tag);
      ctrl_t obs;
      obs = obsOf(g);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s dut%0d op=%h fn=%h: observed %h expected %h", tag, g, curOp, curFn, obs, exp);
      end
   endtask

   // One clock: drive inputs just after the rising edge, compare on the falling edge.
   task automatic cycle(input ctrl_t exp, input logic mr, input logic [5:0] op,
                        input logic [5:0] fn, input logic z, input string tag);
      mem_ready = mr;
      OpCode    = op;
      Funct     = fn;
      Zero      = z;
      @(negedge clk);
      checkNow(curDut, exp, tag);
      @(posedge clk);
      #1;
   endtask

   // Expected per-cycle control for one whole instruction, straight from the ISA rules.
   task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input int stIf,
                           input int stMem, input int zMode, input int abortAfter);
      ctrl_t e;
      int    n;
      logic  z;
      bit rt, relu, lw, sw, beq, mul, andi, lui, slt, jr, jalr, jump, shift, immB, legal;
      n     = 0;
      curOp = op;
      curFn = fn;
      rt    = (op == 6'h00);
      relu  = rt && (fn == 6'h2e);
      lw    = (op == 6'h23);
      sw    = (op == 6'h2b);
      beq   = (op == 6'h04);
      mul   = (op == 6'h1c) && (fn == 6'h02);
      andi  = (op == 6'h0c);
      lui   = (op == 6'h0f);
      slt   = (op == 6'h0a) || (op == 6'h0b);
      jr    = rt && (fn == 6'h08);
      jalr  = rt && (fn == 6'h09);
      jump  = (op == 6'h02) || (op == 6'h03) || jr || jalr;
      shift = rt && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03);
      immB  = lw || sw || lui || andi || slt || op == 6'h08 || op == 6'h09;
      legal = (rt && ((fn inside {6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h2a, 6'h2b})
                      || (fn >= 6'h20 && fn <= 6'h27) || (relu && en)))
           || (op inside {6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f, 6'h23, 6'h2b})
           || mul;

      for (int s = 0; s <= stIf; s++) begin
         e = '0; e.MemRead = 1'b1; e.ALUSrcB = 2'd1;
         e.IRWrite = (s == stIf); e.PCWrite = (s == stIf);
         cycle(e, s == stIf, 6'($urandom), 6'($urandom), 1'($urandom), "IF");
         n++; if (n == abortAfter) return;
      end

      e = '0; e.state = 3'd1; e.ALUSrcB = 2'd3;
      if (!legal) e.illegal = 1'b1;
      else if (jump) begin
         e.PCWrite = 1'b1;
         e.PCSrc   = (jr || jalr) ? 2'd2 : 2'd1;
         if (op == 6'h03) begin e.RegWrite = 1'b1; e.RegDst = 2'd2; e.MemtoReg = 2'd2; end
         if (jalr)        begin e.RegWrite = 1'b1; e.RegDst = 2'd1; e.MemtoReg = 2'd2; end
      end
      cycle(e, 1'($urandom), op, fn, 1'($urandom), "ID");
      n++; if (n == abortAfter || !legal || jump) return;

      z = (zMode == 2) ? 1'($urandom) : 1'(zMode);
      e = '0; e.state = 3'd2;
      e.ALUSrcA = shift ? 2'd2 : 2'd1;
      e.ALUSrcB = immB ? 2'd2 : 2'd0;
      e.ExtOp   = !andi;
      e.LuOp    = lui;
      e.ALUOp   = {op[0], rt ? 3'b010 : beq ? 3'b001 : andi ? 3'b100 : slt ? 3'b101 : mul ? 3'b110 : 3'b000};
      if (beq) begin e.PCWrite = z; e.PCSrc = 2'd3; end
      e.mulStart = mul;
      cycle(e, 1'($urandom), 6'($urandom), 6'($urandom), z, "EX");
      n++; if (n == abortAfter || beq) return;

      if (mul) begin
         logic [3:0] hold;
         hold = e.ALUOp;
         for (int i = 0; i < lat; i++) begin
            e = '0; e.state = 3'd5; e.ALUOp = hold;
            cycle(e, 1'($urandom), 6'($urandom), 6'($urandom), 1'($urandom), "MULW");
            n++; if (n == abortAfter) return;
         end
      end

      if (lw || sw) begin
         for (int s = 0; s <= stMem; s++) begin
            e = '0; e.state = 3'd3; e.IorD = 1'b1; e.MemRead = lw; e.MemWrite = sw;
            cycle(e, s == stMem, 6'($urandom), 6'($urandom), 1'($urandom), "MEM");
            n++; if (n == abortAfter) return;
         end
         if (sw) return;
      end

      e = '0; e.state = 3'd4; e.RegWrite = 1'b1;
      e.RegDst    = (rt || mul) ? 2'd1 : 2'd0;
      e.MemtoReg  = lw ? 2'd1 : 2'd0;
      e.RegWrite2 = relu && en;
      cycle(e, 1'($urandom), 6'($urandom), 6'($urandom), 1'($urandom), "WB");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      pool = '{12'h020, 12'h022, 12'h024, 12'h02a, 12'h000, 12'h003, 12'h008, 12'h009,
               12'h02e, 12'h080, 12'h0c0, 12'h100, 12'h200, 12'h300, 12'h3c0, 12'h280,
               12'h8c0, 12'hac0, 12'h702, 12'hfc0};
      rstN      = 2'b00;
      mem_ready = 1'b1;
      OpCode    = '0;
      Funct     = '0;
      Zero      = 1'b0;
      @(posedge clk); #1;

      // Reset held three cycles: everything zero on both instances.
      for (int i = 0; i < 3; i++) begin
         mem_ready = 1'b1;
         @(negedge clk);
         checkNow(0, '0, "reset");
         checkNow(1, '0, "reset");
         @(posedge clk); #1;
      end
      rstN[0] = 1'b1;

      runInstr(6'h08, 6'h15, 0, 0, 0, 0);   // addi
      runInstr(6'h23, 6'h00, 0, 2, 0, 0);   // lw with two MEM stalls
      runInstr(6'h1c, 6'h02, 0, 0, 0, 0);   // mul
      runInstr(6'h04, 6'h00, 0, 0, 1, 0);   // beq taken
      runInstr(6'h04, 6'h00, 0, 0, 0, 0);   // beq not taken
      runInstr(6'h00, 6'h2e, 0, 0, 0, 0);   // relu enabled
      runInstr(6'h02, 6'h00, 1, 0, 0, 0);   // j with an IF stall
      runInstr(6'h03, 6'h00, 0, 0, 0, 0);   // jal
      runInstr(6'h00, 6'h08, 0, 0, 0, 0);   // jr
      runInstr(6'h00, 6'h09, 0, 0, 0, 0);   // jalr
      runInstr(6'h2b, 6'h00, 0, 1, 0, 0);   // sw with a MEM stall
      runInstr(6'h0c, 6'h00, 0, 0, 0, 0);   // andi
      runInstr(6'h0f, 6'h00, 0, 0, 0, 0);   // lui
      runInstr(6'h0b, 6'h00, 0, 0, 0, 0);   // sltiu
      runInstr(6'h00, 6'h02, 0, 0, 0, 0);   // srl
      runInstr(6'h3f, 6'h00, 0, 0, 0, 0);   // undefined opcode
      runInstr(6'h1c, 6'h00, 0, 0, 0, 0);   // mul opcode with bad funct

      for (int i = 0; i < 80; i++) begin
         logic [11:0] pick;
         pick = pool[$urandom_range(19, 0)];
         runInstr(pick[11:6], pick[5:0], $urandom_range(2, 0), $urandom_range(2, 0), 2, 0);
      end

      // Reset in the middle of MULW: state clears asynchronously, no WB follows.
      runInstr(6'h1c, 6'h02, 0, 0, 0, 5);
      rstN[0] = 1'b0;
      #1;
      checkNow(0, '0, "async reset");
      @(negedge clk);
      checkNow(0, '0, "held reset");
      @(posedge clk); #1;
      rstN[0] = 1'b1;
      runInstr(6'h08, 6'h00, 0, 0, 0, 0);

      // Second instance: relu disabled, shorter mul latency.
      rstN    = 2'b10;
      curDut  = 1;
      lat     = LAT_B;
      en      = 1'b0;
      runInstr(6'h00, 6'h2e, 0, 0, 0, 0);
      runInstr(6'h08, 6'h00, 0, 0, 0, 0);
      runInstr(6'h1c, 6'h02, 0, 0, 0, 0);
      runInstr(6'h00, 6'h20, 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
